// File: rtl/regfile_wb.sv
// Writeback stage feeding the register file write port.
// ALU and load results are queued in order and drained one per cycle.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   mem_* / alu_*       valid/ready write requests (mem has priority)
//   flush               discard every pending write
//   rdReg1, rdReg2      decode read addresses checked for RAW hazards
//   hazard1, hazard2    a pending write targets rdReg1 / rdReg2
//   writeReg, wrReg,
//   wrData, writeFlag   registered regfile write port
//   count               FIFO occupancy
module regfile_wb #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [REG_W-1:0]             mem_reg,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic [1:0]                   mem_flag,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_W-1:0]             alu_reg,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic [1:0]                   alu_flag,
    input  logic                         flush,
    input  logic [REG_W-1:0]             rdReg1,
    input  logic [REG_W-1:0]             rdReg2,
    output logic                         hazard1,
    output logic                         hazard2,
    output logic                         writeReg,
    output logic [REG_W-1:0]             wrReg,
    output logic [DATA_W-1:0]            wrData,
    output logic [1:0]                   writeFlag,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [REG_W-1:0]  rg;
        logic [DATA_W-1:0] data;
        logic [1:0]        flag;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] alu_slot;
    logic [PW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          mem_push;
    logic          alu_push;
    logic          pop;
    entry_t        head;

    // Readiness looks only at occupancy at the start of the cycle;
    // the entry drained this cycle is not credited.
    assign mem_ready = (cnt <= CW'(DEPTH-1)) && !flush;
    assign alu_ready = !flush &&
                       (mem_valid ? (cnt <= CW'(DEPTH-2))
                                  : (cnt <= CW'(DEPTH-1)));

    assign mem_push = mem_valid && mem_ready;
    assign alu_push = alu_valid && alu_ready;
    assign pop      = (cnt != '0) && !flush;
    assign head     = q[rd_ptr];
    assign count    = cnt;

    // When both are accepted the alu entry lands behind the mem entry.
    assign alu_slot = wr_ptr + PW'(mem_push);

    assign cnt_next = cnt + CW'(mem_push) + CW'(alu_push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (mem_push) begin
            q[wr_ptr] <= '{rg: mem_reg, data: mem_data, flag: mem_flag};
        end
        if (alu_push) begin
            q[alu_slot] <= '{rg: alu_reg, data: alu_data, flag: alu_flag};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            writeReg  <= 1'b0;
            wrReg     <= '0;
            wrData    <= '0;
            writeFlag <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            writeReg <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            rd_ptr   <= rd_ptr + PW'(pop);
            cnt      <= cnt_next;
            writeReg <= pop;
            if (pop) begin
                wrReg     <= head.rg;
                wrData    <= head.data;
                writeFlag <= head.flag;
            end
        end
    end

    // Only the cnt entries starting at rd_ptr are live.
    always_comb begin
        hazard1 = writeReg && (wrReg == rdReg1);
        hazard2 = writeReg && (wrReg == rdReg2);
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < cnt) begin
                if (q[idx].rg == rdReg1) hazard1 = 1'b1;
                if (q[idx].rg == rdReg2) hazard2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed vector bench for regfile_wb.
// Table of per-cycle stimulus/expectations plus stream and reset sequences.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        mem_valid, alu_valid, flush;
    logic        mem_ready, alu_ready;
    logic [3:0]  mem_reg, alu_reg, rdReg1, rdReg2;
    logic [15:0] mem_data, alu_data;
    logic [1:0]  mem_flag, alu_flag;
    logic        hazard1, hazard2, writeReg;
    logic [3:0]  wrReg;
    logic [15:0] wrData;
    logic [1:0]  writeFlag;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    regfile_wb #(.DEPTH(4), .DATA_W(16), .REG_W(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg(mem_reg), .mem_data(mem_data), .mem_flag(mem_flag),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_reg(alu_reg), .alu_data(alu_data), .alu_flag(alu_flag),
        .flush(flush), .rdReg1(rdReg1), .rdReg2(rdReg2),
        .hazard1(hazard1), .hazard2(hazard2),
        .writeReg(writeReg), .wrReg(wrReg), .wrData(wrData),
        .writeFlag(writeFlag), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    typedef struct {
        logic        mv;
        logic [3:0]  mr;
        logic [15:0] md;
        logic [1:0]  mf;
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        logic [1:0]  af;
        logic        fl;
        logic [3:0]  r1, r2;
        logic        e_mrdy, e_ardy, e_h1, e_h2;
        logic [2:0]  e_cnt;
        logic        e_we;
        logic [3:0]  e_wreg;
        logic [15:0] e_wdata;
        logic [1:0]  e_wflag;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic mv, input logic [3:0] mr, input logic [15:0] md,
        input logic [1:0] mf,
        input logic av, input logic [3:0] ar, input logic [15:0] ad,
        input logic [1:0] af,
        input logic fl, input logic [3:0] r1, input logic [3:0] r2,
        input logic e_mrdy, input logic e_ardy,
        input logic e_h1, input logic e_h2, input logic [2:0] e_cnt,
        input logic e_we, input logic [3:0] e_wreg,
        input logic [15:0] e_wdata, input logic [1:0] e_wflag);
        vec_t v;
        v.mv = mv; v.mr = mr; v.md = md; v.mf = mf;
        v.av = av; v.ar = ar; v.ad = ad; v.af = af;
        v.fl = fl; v.r1 = r1; v.r2 = r2;
        v.e_mrdy = e_mrdy; v.e_ardy = e_ardy;
        v.e_h1 = e_h1; v.e_h2 = e_h2; v.e_cnt = e_cnt;
        v.e_we = e_we; v.e_wreg = e_wreg;
        v.e_wdata = e_wdata; v.e_wflag = e_wflag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_reg = 0; mem_data = 0; mem_flag = 0;
        alu_valid = 0; alu_reg = 0; alu_data = 0; alu_flag = 0;
        flush = 0; rdReg1 = 0; rdReg2 = 0;
    endtask

    typedef struct {
        logic [3:0]  rg;
        logic [15:0] data;
        logic [1:0]  flag;
    } wr_t;

    wr_t exp_q[$];

    initial begin
        vec_t v;
        wr_t  w;
        int   mi, ai, seen, cyc;

        rst = 1'b0;
        idle_inputs();

        // mv mr md mf | av ar ad af | fl r1 r2 | mrdy ardy h1 h2 cnt we wreg wdata wflag
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,0,0,   1,1,0,0,0,0,0,16'h0,0));
        vt.push_back(mk(1,3,16'h00AB,1,0,0,16'h0,0,    0,3,6,   1,1,0,0,0,0,0,16'h0,0));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,3,6,   1,1,1,0,1,0,0,16'h0,0));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,3,6,   1,1,1,0,0,1,3,16'h00AB,1));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,3,6,   1,1,0,0,0,0,3,16'h00AB,1));
        vt.push_back(mk(1,0,16'h1000,0,1,8,16'h2008,2, 0,5,6,   1,1,0,0,0,0,3,16'h00AB,1));
        vt.push_back(mk(1,1,16'h1001,1,1,9,16'h2009,3, 0,8,0,   1,1,1,1,2,0,3,16'h00AB,1));
        vt.push_back(mk(1,2,16'h1002,0,1,10,16'h200A,1,0,0,2,   1,0,1,0,3,1,0,16'h1000,0));
        vt.push_back(mk(1,3,16'h1003,1,1,10,16'h200A,1,0,10,9,  1,0,0,1,3,1,8,16'h2008,2));
        vt.push_back(mk(0,0,16'h0,0,   1,10,16'h200A,1,0,3,1,   1,1,1,1,3,1,1,16'h1001,1));
        vt.push_back(mk(1,4,16'h1004,2,1,11,16'h200B,0,0,9,4,   1,0,1,0,3,1,9,16'h2009,3));
        vt.push_back(mk(0,0,16'h0,0,   1,11,16'h200B,0,0,0,11,  1,1,0,0,3,1,2,16'h1002,0));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,11,3,  1,1,1,1,3,1,3,16'h1003,1));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,10,4,  1,1,1,1,2,1,10,16'h200A,1));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,4,11,  1,1,1,1,1,1,4,16'h1004,2));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,11,4,  1,1,1,0,0,1,11,16'h200B,0));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,11,4,  1,1,0,0,0,0,11,16'h200B,0));
        vt.push_back(mk(1,5,16'h3005,1,1,6,16'h3006,2, 0,5,6,   1,1,0,0,0,0,11,16'h200B,0));
        vt.push_back(mk(1,7,16'h3007,3,1,12,16'h300C,0,0,5,6,   1,1,1,1,2,0,11,16'h200B,0));
        vt.push_back(mk(1,13,16'h300D,1,1,14,16'h300E,2,1,6,5,  0,0,1,1,3,1,5,16'h3005,1));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,6,7,   1,1,0,0,0,0,5,16'h3005,1));
        vt.push_back(mk(0,0,16'h0,0,   0,0,16'h0,0,    0,12,13, 1,1,0,0,0,0,5,16'h3005,1));

        @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_we", 32'(writeReg), 0);
        chk("rst_wrdata", 32'(wrData), 0);
        chk("rst_hz", 32'({hazard1, hazard2}), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            mem_valid = v.mv; mem_reg = v.mr; mem_data = v.md; mem_flag = v.mf;
            alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad; alu_flag = v.af;
            flush = v.fl; rdReg1 = v.r1; rdReg2 = v.r2;
            #1;
            chk($sformatf("v%0d_mrdy", i), 32'(mem_ready), 32'(v.e_mrdy));
            chk($sformatf("v%0d_ardy", i), 32'(alu_ready), 32'(v.e_ardy));
            chk($sformatf("v%0d_h1", i), 32'(hazard1), 32'(v.e_h1));
            chk($sformatf("v%0d_h2", i), 32'(hazard2), 32'(v.e_h2));
            chk($sformatf("v%0d_cnt", i), 32'(count), 32'(v.e_cnt));
            chk($sformatf("v%0d_we", i), 32'(writeReg), 32'(v.e_we));
            chk($sformatf("v%0d_wreg", i), 32'(wrReg), 32'(v.e_wreg));
            chk($sformatf("v%0d_wdata", i), 32'(wrData), 32'(v.e_wdata));
            chk($sformatf("v%0d_wflag", i), 32'(writeFlag), 32'(v.e_wflag));
            @(negedge clk);
        end
        idle_inputs();

        // Stream: both sources valid until 6 writes each, across pointer wrap.
        mi = 0; ai = 0; seen = 0; cyc = 0;
        while (seen < 12 && cyc < 60) begin
            mem_valid = (mi < 6);
            mem_reg = 4'(mi); mem_data = 16'h5000 + 16'(mi);
            mem_flag = 2'(mi);
            alu_valid = (ai < 6);
            alu_reg = 4'(8 + ai); alu_data = 16'h6000 + 16'(ai);
            alu_flag = 2'(ai + 1);
            #1;
            checks++;
            if (count > 3'd4) begin
                errors++;
                $display("FAIL stream_cnt actual=%0d required<=4", count);
            end
            if (writeReg) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_extra actual=%0h required=none", wrReg);
                end else begin
                    w = exp_q.pop_front();
                    chk($sformatf("stream_%0d", seen),
                        32'({wrReg, wrData, writeFlag}),
                        32'({w.rg, w.data, w.flag}));
                end
                seen++;
            end
            if (mem_valid && mem_ready) begin
                exp_q.push_back('{4'(mi), 16'h5000 + 16'(mi), 2'(mi)});
                mi++;
            end
            if (alu_valid && alu_ready) begin
                exp_q.push_back('{4'(8 + ai), 16'h6000 + 16'(ai), 2'(ai + 1)});
                ai++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("stream_seen", 32'(seen), 12);
        idle_inputs();
        @(negedge clk);

        // Asynchronous reset while two writes are pending.
        mem_valid = 1; mem_reg = 1; mem_data = 16'h7001; mem_flag = 1;
        alu_valid = 1; alu_reg = 2; alu_data = 16'h7002; alu_flag = 2;
        @(negedge clk);
        alu_valid = 0;
        mem_reg = 3; mem_data = 16'h7003; mem_flag = 3;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre_rst_cnt", 32'(count), 2);
        chk("pre_rst_we", 32'(writeReg), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_cnt", 32'(count), 0);
        chk("async_we", 32'(writeReg), 0);
        chk("async_wreg", 32'(wrReg), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_rst_we%0d", i), 32'(writeReg), 0);
            chk($sformatf("post_rst_cnt%0d", i), 32'(count), 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
